// File: rtl/onehot_monitor.sv
// Purpose: per-channel onehot/onehot0 checker with arming delay, saturating
//          error counters, sticky flags and a first-failure capture.
// Ports:   clk, rst (async active-low), en/mode per channel, sig packed
//          NCH*WIDTH, clr (sync clear); err_now/err_sticky/err_cnt per
//          channel, ff_valid/ff_ch/ff_val first-failure capture.
//          err_now has one cycle of latency; there is no backpressure.
module onehot_monitor #(
  parameter int WIDTH   = 32,
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int ARM_CYC = 2,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         mode,
  input  logic [NCH*WIDTH-1:0]   sig,
  input  logic                   clr,
  output logic [NCH-1:0]         err_now,
  output logic [NCH-1:0]         err_sticky,
  output logic [NCH*CNT_W-1:0]   err_cnt,
  output logic                   ff_valid,
  output logic [CH_W-1:0]        ff_ch,
  output logic [WIDTH-1:0]       ff_val
);

  typedef enum logic [1:0] {IDLE, ARMING, CHECK} state_t;

  localparam int AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  // Counter value on the final arming cycle; unused when ARM_CYC is 0.
  localparam logic [AW-1:0] ARM_LAST = AW'((ARM_CYC > 0) ? ARM_CYC - 1 : 0);

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [AW-1:0]    arm_q   [NCH];
  logic [AW-1:0]    arm_d   [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [NCH-1:0]   viol;

  // Next-state logic for all channel FSMs; en low always wins.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      arm_d[i]   = arm_q[i];
      if (!en[i]) begin
        state_d[i] = IDLE;
        arm_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            arm_d[i]   = '0;
            state_d[i] = (ARM_CYC == 0) ? CHECK : ARMING;
          end
          ARMING: begin
            if (arm_q[i] == ARM_LAST) begin
              state_d[i] = CHECK;
              arm_d[i]   = '0;
            end else begin
              arm_d[i] = arm_q[i] + 1'b1;
            end
          end
          CHECK:   state_d[i] = CHECK;
          default: state_d[i] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        arm_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        arm_q[i]   <= arm_d[i];
      end
    end
  end

  // s & (s-1) is nonzero exactly when two or more bits are set, so no
  // full popcount is needed for either rule.
  for (genvar g = 0; g < NCH; g++) begin : g_viol
    logic [WIDTH-1:0] s;
    logic             multi;
    logic             zero;
    assign s       = sig[g*WIDTH +: WIDTH];
    assign multi   = |(s & (s - WIDTH'(1)));
    assign zero    = ~|s;
    assign viol[g] = (state_q[g] == CHECK) && (multi || (!mode[g] && zero));
    assign err_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  // Lowest violating channel: scan downward so the smallest index is last.
  logic [CH_W-1:0]  sel_ch;
  logic [WIDTH-1:0] sel_val;
  always_comb begin
    sel_ch  = '0;
    sel_val = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (viol[i]) begin
        sel_ch  = CH_W'(i);
        sel_val = sig[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_now    <= '0;
      err_sticky <= '0;
      ff_valid   <= 1'b0;
      ff_ch      <= '0;
      ff_val     <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else if (clr) begin
      // clr discards any violation seen on this same edge.
      err_now    <= '0;
      err_sticky <= '0;
      ff_valid   <= 1'b0;
      ff_ch      <= '0;
      ff_val     <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      err_now    <= viol;
      err_sticky <= err_sticky | viol;
      for (int i = 0; i < NCH; i++) begin
        if (viol[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (!ff_valid && (|viol)) begin
        ff_valid <= 1'b1;
        ff_ch    <= sel_ch;
        ff_val   <= sel_val;
      end
    end
  end

endmodule
